// File: rtl/display_pkg.sv
// Shared display definitions: digit index encoding used by both the scan
// controller and the digit mux, plus the scan FSM state type.
package display_pkg;

    localparam int DIG_MIN0   = 0;
    localparam int DIG_MIN1   = 1;
    localparam int DIG_COLON  = 2;
    localparam int DIG_HOUR0  = 3;
    localparam int DIG_HOUR1  = 4;
    localparam int NUM_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    // hour1 wraps back to min0; every other index simply steps by one
    function automatic logic [2:0] next_sel(input logic [2:0] s);
        return (s == 3'(DIG_HOUR1)) ? 3'(DIG_MIN0) : s + 3'd1;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_scan_timer.sv
// Loadable down-counter that times the blank and lit phases of each slot.
// Holds at zero instead of wrapping, so it never underflows.
module scan_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller for the five-position clock display: steps the mux select
// through each position with a blanking gap before every lit period.
module digit_scan_ctrl
    import display_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 1000,
    parameter int BLANK_TICKS     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] digit_mask,
    output logic [2:0] sel,
    output logic [4:0] dig_en_n,
    output logic       blank,
    output logic       frame_done
);

    localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);

    scan_state_t      state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             mask_q, mask_d;
    logic [4:0]       dig_en_n_q, dig_en_n_d;
    logic             blank_q, blank_d;
    logic             frame_done_q, frame_done_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        if (!enable) begin
            state_d  = IDLE;
            sel_d    = 3'(DIG_MIN0);
            mask_d   = 1'b0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    sel_d    = 3'(DIG_MIN0);
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                end
                BLANK: begin
                    if (tmr_zero) begin
                        state_d  = ON;
                        mask_d   = digit_mask[sel_q];
                        tmr_load = 1'b1;
                        tmr_val  = ON_LOAD;
                    end
                end
                ON: begin
                    if (tmr_zero) begin
                        state_d      = BLANK;
                        sel_d        = next_sel(sel_q);
                        frame_done_d = (sel_q == 3'(DIG_HOUR1));
                        tmr_load     = 1'b1;
                        tmr_val      = BLANK_LOAD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 3'(DIG_MIN0);
                end
            endcase
        end

        // Outputs are derived from the next state so they register in step with it
        blank_d    = (state_d != ON) || mask_d;
        dig_en_n_d = blank_d ? 5'b11111 : ~(5'b00001 << sel_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 3'(DIG_MIN0);
            mask_q       <= 1'b0;
            dig_en_n_q   <= 5'b11111;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            dig_en_n_q   <= dig_en_n_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    sel_in_range: assert property (@(posedge clk) disable iff (reset) sel_q < 3'(NUM_DIGITS));

    assign sel        = sel_q;
    assign dig_en_n   = dig_en_n_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: drives scan scenarios and random masks/enables,
// comparing every cycle against a slot-arithmetic reference model.
module tb_digit_scan_ctrl;

    localparam int T    = 4;
    localparam int B    = 2;
    localparam int SLOT = T + B;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] digit_mask = 5'b0;
    logic [2:0] sel;
    logic [4:0] dig_en_n;
    logic       blank;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    // reference model: cycles elapsed since scanning started
    bit running = 1'b0;
    int run_t = 0;
    bit mflag = 1'b0;

    digit_scan_ctrl #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_mask (digit_mask),
        .sel        (sel),
        .dig_en_n   (dig_en_n),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model_out();
        int slot;
        int ph;
        bit lit;
        logic [4:0] onehot;
        logic [4:0] en;
        bit fd;
        if (!running) return {3'd0, 5'b11111, 1'b1, 1'b0};
        slot   = (run_t / SLOT) % 5;
        ph     = run_t % SLOT;
        lit    = (ph >= B) && !mflag;
        onehot = 5'b00001 << slot;
        en     = lit ? ~onehot : 5'b11111;
        fd     = (ph == 0) && (run_t > 0) && (slot == 0);
        return {3'(slot), en, !lit, fd};
    endfunction

    // advance one clock and the model with it; leaves time at posedge+1
    task automatic tick();
        @(posedge clk);
        if (reset || !enable) begin
            running = 1'b0;
        end else if (!running) begin
            running = 1'b1;
            run_t   = 0;
        end else begin
            run_t++;
        end
        if (running && (run_t % SLOT) == B) mflag = digit_mask[(run_t / SLOT) % 5];
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        #2;
        checks++;
        if ({sel, dig_en_n, blank, frame_done} !== {3'd0, 5'b11111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", {sel, dig_en_n, blank, frame_done}, {3'd0, 5'b11111, 1'b1, 1'b0});
        end
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", i, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
    endtask

    task automatic test_scan();
        int fd_count = 0;
        int fd_first = -1;
        digit_mask = 5'b00000;
        enable = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                fd_count++;
                if (fd_first < 0) fd_first = i;
            end
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL scan t=%0d got=%b exp=%b", i, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
        checks++;
        if (fd_count !== 2 || fd_first !== 30) begin
            errors++;
            $display("FAIL scan_frame_done count=%0d first=%0d exp count=2 first=30", fd_count, fd_first);
        end
    endtask

    task automatic test_mask();
        int fd_count = 0;
        digit_mask = 5'b10100;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (frame_done === 1'b1) fd_count++;
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL mask t=%0d got=%b exp=%b", run_t, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
        checks++;
        if (fd_count !== 2) begin
            errors++;
            $display("FAIL mask_frame_len frame_done count=%0d exp=2", fd_count);
        end
    endtask

    task automatic test_mask_midslot();
        int lit1 = 0;
        enable = 1'b0;
        digit_mask = 5'b00000;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (run_t == 9) digit_mask = 5'b11111;
            else if (run_t > 12 && $urandom_range(0, 2) == 0) digit_mask = 5'($urandom);
            if (run_t >= 8 && run_t <= 11 && dig_en_n === 5'b11101) lit1++;
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL mask_mid t=%0d got=%b exp=%b", run_t, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
        checks++;
        if (lit1 !== 4) begin
            errors++;
            $display("FAIL mask_mid_slot1 lit cycles=%0d exp=4", lit1);
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        digit_mask = 5'b00000;
        tick();
        enable = 1'b1;
        do tick(); while (run_t < 22);
        enable = 1'b0;
        tick();
        checks++;
        if ({sel, dig_en_n, blank, frame_done} !== {3'd0, 5'b11111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL enable_drop got=%b exp=%b", {sel, dig_en_n, blank, frame_done}, {3'd0, 5'b11111, 1'b1, 1'b0});
        end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL enable_restart t=%0d got=%b exp=%b", run_t, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        do tick(); while (run_t < 14);
        checks++;
        if (dig_en_n !== 5'b11011) begin
            errors++;
            $display("FAIL areset_pre dig_en_n=%b exp=11011", dig_en_n);
        end
        #3;
        reset = 1'b1;
        running = 1'b0;
        #1;
        checks++;
        if ({sel, dig_en_n, blank, frame_done} !== {3'd0, 5'b11111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL areset_now got=%b exp=%b", {sel, dig_en_n, blank, frame_done}, {3'd0, 5'b11111, 1'b1, 1'b0});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL areset_restart t=%0d got=%b exp=%b", run_t, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 5) == 0) digit_mask = 5'($urandom);
            tick();
            checks++;
            if ({sel, dig_en_n, blank, frame_done} !== model_out()) begin
                errors++;
                $display("FAIL random c=%0d got=%b exp=%b", i, {sel, dig_en_n, blank, frame_done}, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mask();
        test_mask_midslot();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan controller for the five-position clock display (min0, min1, colon, hour0, hour1). It generates the 3-bit digit-select code that drives the display digit mux and the active-low common-anode enables for each position. Between positions it inserts a blanking gap to suppress ghosting. It sits between the system clock domain and the display pins, alongside the digit mux and the seven-segment decoder.

## Interface
Parameters:
- TICKS_PER_DIGIT, 1000: cycles each position is lit; legal range ≥ 1.
- BLANK_TICKS, 8: cycles all enables are off before each position lights; legal range ≥ 1.

Ports:
- clk  in  1  system clock. The block uses one clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scanning runs while high; low forces idle (display dark).
- digit_mask  in  5  bit i = 1 keeps position i dark for its slot. The slot timing is unchanged.
- sel  out  3  digit index to the mux: 0 = min0, 1 = min1, 2 = colon, 3 = hour0, 4 = hour1.
- dig_en_n  out  5  active-low enables; bit i drives position i; at most one bit low.
- blank  out  1  high whenever all of dig_en_n are high.
- frame_done  out  1  one-cycle pulse after the hour1 lit period ends.

## Operation
- FSM states: IDLE, BLANK, ON.
- IDLE behaviour:
  - sel = 0, dig_en_n = 5'b11111, blank = 1.
  - When enable = 1, go to BLANK with sel = 0 and load the counter with BLANK_TICKS-1.
- BLANK behaviour:
  - All enables are off. The counter decrements.
  - At 0, go to ON and load the counter with TICKS_PER_DIGIT-1.
  - Sample digit_mask[sel] into a mask flag on this transition.
- ON behaviour:
  - dig_en_n[sel] = 0 unless the mask flag is set. If set, all enables stay high.
  - The counter decrements. At 0, go to BLANK and advance sel: 4 wraps to 0, no other values skipped.
  - If sel was 4, assert frame_done for the first cycle of the following BLANK.
- blank = 1 in IDLE, in BLANK, and in ON when the mask flag is set.
- enable = 0 in any state: go to IDLE on the next edge. sel returns to 0, no frame_done, counter cleared.
- digit_mask changes take effect only at a BLANK→ON boundary. A lit position never changes mid-slot.
- sel is never ≥ 5; reaching a value ≥ 5 is a design error, asserted in simulation.
- Counter width = $clog2(max(TICKS_PER_DIGIT, BLANK_TICKS)), with a minimum of 1. The counter counts down only and never underflows.

## Timing
- All outputs are registered. Reset values: sel = 0, dig_en_n = 5'b11111, blank = 1, frame_done = 0, state = IDLE.
- enable sampled high at edge 0:
  - Edges 0 to BLANK_TICKS-1: BLANK with sel = 0.
  - Edge BLANK_TICKS: first ON cycle.
- Slot length = BLANK_TICKS + TICKS_PER_DIGIT cycles. Frame = 5 × slot.
- sel changes only on BLANK entry, so the mux output settles for BLANK_TICKS cycles before any enable goes low.
- frame_done is coincident with the first BLANK cycle of sel = 0 in the next frame.
- Reset asserted mid-slot: all outputs go to reset values immediately, with no clock required. After release, scanning restarts at sel = 0 on the first edge with enable = 1.

## Structure
- Shared package display_pkg:
  - Digit index constants DIG_MIN0 = 0, DIG_MIN1 = 1, DIG_COLON = 2, DIG_HOUR0 = 3, DIG_HOUR1 = 4, and NUM_DIGITS = 5.
  - The scan_state_t enum (IDLE, BLANK, ON).
  - The digit mux and this block both import the index constants, so the encodings cannot diverge.
- One sub-module, scan_timer:
  - Loadable down-counter with load value, load strobe and zero flag.
  - Instantiated once; the FSM drives its load.

## Test plan
Parameters for all scenarios: TICKS_PER_DIGIT = 4, BLANK_TICKS = 2.
- Reset with enable = 0 for 10 cycles -> sel = 0, dig_en_n = 5'b11111, blank = 1, frame_done never high.
- enable = 1 and digit_mask = 0, run 60 cycles:
  - Sequence per slot: 2 cycles blank, then 4 cycles of dig_en_n = 11110, 11101, 11011, 10111, 01111 in turn.
  - sel steps 0 to 4. frame_done pulses at cycles 30 and 60 after enable.
- digit_mask = 5'b10100 (colon and hour1 dark) -> slots 2 and 4 stay all-high for 4 cycles, with blank = 1. Frame length is still 30 cycles.
- digit_mask toggled mid-ON of slot 1 -> slot 1 is unaffected; the new mask applies from slot 2 onward.
- enable dropped during the 3rd ON cycle of slot 3 -> next edge gives IDLE, sel = 0, all enables high, no frame_done. Re-enable restarts at slot 0 with the 2-cycle blank.
- reset pulsed asynchronously, between edges, during ON of slot 2 -> dig_en_n = 11111 and sel = 0 before the next clock edge.
